// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: multiplexed 4-digit BCD display scanner.
// Cycles SHOW (DIV cycles) / GAP (GAP cycles) over four digits, drives a
// shared 7-segment decoder, and optionally suppresses leading zeros.
// Every output is a flop whose next value is derived from next-state values,
// so what is displayed lines up with the state register it belongs to.
module led_scan_ctrl #(
  parameter int DIV = 1000,
  parameter int GAP = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] bcd_data,
  input  logic        load,
  input  logic        run,
  input  logic        lz_en,
  output logic [3:0]  dec_in,
  output logic        dec_n_en,
  output logic [3:0]  dig_n_sel,
  output logic        frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  localparam logic [15:0] SHOW_LAST = 16'(DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic        shadow_vld_q, shadow_vld_d;
  logic [15:0] active_q, active_d;
  logic [3:0]  dec_in_q, dec_in_d;
  logic        dec_n_en_q, dec_n_en_d;
  logic [3:0]  dig_n_sel_q, dig_n_sel_d;
  logic        frame_done_q, frame_done_d;

  logic [3:0]  nib_zero;   // active_d nibble i is zero
  logic [3:0]  lead_zero;  // digits 3..i of active_d are all zero (never for digit 0)

  // Next state: shadow capture, scan sequencing, frame latch and frame_done.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    frame_done_d = 1'b0;
    shadow_d     = load ? bcd_data : shadow_q;
    shadow_vld_d = shadow_vld_q | load;
    if (!run) begin
      state_d = S_IDLE;
      idx_d   = 2'd0;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (shadow_vld_q) begin
            state_d  = S_SHOW;
            idx_d    = 2'd0;
            cnt_d    = 16'd0;
            active_d = shadow_q;  // registered shadow, so a same-edge load waits a frame
          end
        end
        S_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d      = S_GAP;
            cnt_d        = 16'd0;
            frame_done_d = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_SHOW;
            cnt_d   = 16'd0;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) active_d = shadow_q;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Leading-zero chain walked from the most significant digit downward.
  always_comb begin
    for (int i = 0; i < 4; i++) nib_zero[i] = (active_d[4*i +: 4] == 4'd0);
    lead_zero[3] = nib_zero[3];
    lead_zero[2] = lead_zero[3] & nib_zero[2];
    lead_zero[1] = lead_zero[2] & nib_zero[1];
    lead_zero[0] = 1'b0;
  end

  // Output next values from next state; GAP keeps dec_in, blanks everything else.
  always_comb begin
    dec_in_d    = dec_in_q;
    dec_n_en_d  = 1'b1;
    dig_n_sel_d = 4'b1111;
    case (state_d)
      S_IDLE: dec_in_d = 4'd0;
      S_SHOW: begin
        dec_in_d = active_d[{idx_d, 2'b00} +: 4];
        if (!(lz_en && lead_zero[idx_d])) begin
          dec_n_en_d  = 1'b0;
          dig_n_sel_d = ~(4'b0001 << idx_d);
        end
      end
      default: ;
    endcase
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 16'd0;
      shadow_q     <= 16'd0;
      shadow_vld_q <= 1'b0;
      active_q     <= 16'd0;
      dec_in_q     <= 4'd0;
      dec_n_en_q   <= 1'b1;
      dig_n_sel_q  <= 4'b1111;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      active_q     <= active_d;
      dec_in_q     <= dec_in_d;
      dec_n_en_q   <= dec_n_en_d;
      dig_n_sel_q  <= dig_n_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dec_in     = dec_in_q;
  assign dec_n_en   = dec_n_en_q;
  assign dig_n_sel  = dig_n_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: a frame-position model queues the expected output
// word after every clock edge; each scenario task pops and compares it, and
// adds a few fixed-value checks on top.
module tb_led_scan_ctrl;
  localparam int DIV   = 4;
  localparam int GAP   = 2;
  localparam int P     = DIV + GAP;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [15:0] bcd_data = 16'h0;
  logic        load = 1'b0, run = 1'b0, lz_en = 1'b0;
  logic [3:0]  dec_in;
  logic        dec_n_en;
  logic [3:0]  dig_n_sel;
  logic        frame_done;
  logic [9:0]  obs;

  int checks = 0;
  int errors = 0;

  logic [9:0]  sb[$];
  int          m_pos = 0, m_dig = 0;
  bit          m_scan = 0, m_vld = 0;
  logic [15:0] m_shadow = 16'h0, m_active = 16'h0;
  logic [3:0]  m_nib;

  always #5 clk = ~clk;

  led_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
    .clk(clk), .n_rst(n_rst), .bcd_data(bcd_data), .load(load), .run(run),
    .lz_en(lz_en), .dec_in(dec_in), .dec_n_en(dec_n_en), .dig_n_sel(dig_n_sel),
    .frame_done(frame_done)
  );

  assign obs = {dec_in, dec_n_en, dig_n_sel, frame_done};

  // Model: position within the frame decides digit and SHOW/GAP phase.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_scan = 0; m_pos = 0; m_vld = 0; m_shadow = 16'h0; m_active = 16'h0;
      sb.delete();
    end else begin
      if (!run) m_scan = 0;
      else if (!m_scan) begin
        if (m_vld) begin m_scan = 1; m_pos = 0; m_active = m_shadow; end
      end else begin
        m_pos = (m_pos + 1) % FRAME;
        if (m_pos == 0) m_active = m_shadow;
      end
      if (load) begin m_shadow = bcd_data; m_vld = 1; end
      if (!m_scan) sb.push_back({4'h0, 1'b1, 4'hF, 1'b0});
      else begin
        m_dig = m_pos / P;
        m_nib = 4'((m_active >> (4 * m_dig)) & 16'hF);
        if ((m_pos % P) >= DIV)
          sb.push_back({m_nib, 1'b1, 4'hF, (m_dig == 3 && (m_pos % P) == DIV)});
        else if (lz_en && m_dig > 0 && (m_active >> (4 * m_dig)) == 0)
          sb.push_back({m_nib, 1'b1, 4'hF, 1'b0});
        else
          sb.push_back({m_nib, 1'b0, ~(4'b0001 << m_dig), 1'b0});
      end
    end
  end

  task automatic test_reset();
    logic [9:0] ev;
    n_rst = 0; run = 0; load = 0;
    @(negedge clk);
    checks++;
    if (obs !== 10'b0000_1_1111_0) begin errors++; $display("FAIL reset_state: got %h required %h", obs, 10'b0000_1_1111_0); end
    n_rst = 1; run = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL reset_idle c%0d: nothing queued, got %h", c, obs); end
      else begin ev = sb.pop_front(); if (obs !== ev) begin errors++; $display("FAIL reset_idle c%0d: got %h required %h", c, obs, ev); end end
    end
  endtask

  task automatic test_basic();
    logic [9:0] ev;
    int first_fd = -1, nfd = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 0) begin bcd_data = 16'h1234; load = 1; end else load = 0;
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL basic c%0d: nothing queued, got %h", c, obs); end
      else begin ev = sb.pop_front(); if (obs !== ev) begin errors++; $display("FAIL basic c%0d: got %h required %h", c, obs, ev); end end
      if (frame_done) begin nfd++; if (first_fd < 0) first_fd = c; end
      if (c == 1) begin
        checks++;
        if ({dec_in, dig_n_sel, dec_n_en} !== {4'h4, 4'b1110, 1'b0}) begin errors++; $display("FAIL basic_digit0: got %h required %h", {dec_in, dig_n_sel, dec_n_en}, {4'h4, 4'b1110, 1'b0}); end
      end
      if (c == 7) begin
        checks++;
        if ({dec_in, dig_n_sel} !== {4'h3, 4'b1101}) begin errors++; $display("FAIL basic_digit1: got %h required %h", {dec_in, dig_n_sel}, {4'h3, 4'b1101}); end
      end
    end
    checks++;
    if (nfd != 2 || first_fd != 23) begin errors++; $display("FAIL frame_done_period: got count %0d first %0d required 2 / 23", nfd, first_fd); end
  endtask

  task automatic test_lz();
    logic [9:0] ev;
    int lit_a = 0, good_a = 0, lit_b = 0, good_b = 0;
    lz_en = 1;
    for (int c = 0; c < 120; c++) begin
      if (c == 0) begin bcd_data = 16'h0050; load = 1; end
      else if (c == 60) begin bcd_data = 16'h0000; load = 1; end
      else load = 0;
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL lz c%0d: nothing queued, got %h", c, obs); end
      else begin ev = sb.pop_front(); if (obs !== ev) begin errors++; $display("FAIL lz c%0d: got %h required %h", c, obs, ev); end end
      if (c >= 36 && c < 60 && !dec_n_en) begin
        lit_a++;
        if ((dig_n_sel == 4'b1101 && dec_in == 4'h5) || (dig_n_sel == 4'b1110 && dec_in == 4'h0)) good_a++;
      end
      if (c >= 96 && !dec_n_en) begin
        lit_b++;
        if (dig_n_sel == 4'b1110 && dec_in == 4'h0) good_b++;
      end
    end
    checks++;
    if (lit_a != 8 || good_a != 8) begin errors++; $display("FAIL lz_0050: got lit %0d good %0d required 8 / 8", lit_a, good_a); end
    checks++;
    if (lit_b != 4 || good_b != 4) begin errors++; $display("FAIL lz_0000: got lit %0d good %0d required 4 / 4", lit_b, good_b); end
    lz_en = 0;
  endtask

  task automatic test_load_timing();
    logic [9:0] ev;
    logic [3:0] prev_sel = 4'hF;
    logic [3:0] d3[$];
    int ph = 0;
    for (int c = 0; c < 130; c++) begin
      load = 0;
      if (ph == 0 && m_scan && m_pos == P) begin bcd_data = 16'h9999; load = 1; ph = 1; end
      else if (ph == 1 && m_pos == FRAME - 1) begin bcd_data = 16'h5678; load = 1; ph = 2; end
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL load_timing c%0d: nothing queued, got %h", c, obs); end
      else begin ev = sb.pop_front(); if (obs !== ev) begin errors++; $display("FAIL load_timing c%0d: got %h required %h", c, obs, ev); end end
      if (ph > 0 && dig_n_sel == 4'b0111 && prev_sel != 4'b0111) d3.push_back(dec_in);
      prev_sel = dig_n_sel;
    end
    load = 0;
    checks++;
    if (ph != 2 || d3.size() < 3) begin errors++; $display("FAIL load_seq: got phase %0d frames %0d required 2 / >=3", ph, d3.size()); end
    else if (d3[0] !== 4'h0 || d3[1] !== 4'h9 || d3[2] !== 4'h5) begin
      errors++; $display("FAIL load_seq: got digit3 %h %h %h required 0 9 5", d3[0], d3[1], d3[2]);
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] ev;
    int lit = 0;
    bit found = 0;
    for (int c = 0; c < 12 && !found; c++) begin
      if (m_scan && (m_pos % P) < DIV) found = 1;
      else begin
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL async_pre c%0d: nothing queued, got %h", c, obs); end
        else begin ev = sb.pop_front(); if (obs !== ev) begin errors++; $display("FAIL async_pre c%0d: got %h required %h", c, obs, ev); end end
      end
    end
    checks++;
    if (!found || dec_n_en !== 1'b0) begin errors++; $display("FAIL async_setup: got found %0d en %b required 1 / 0", found, dec_n_en); end
    #2 n_rst = 0;
    #1;
    checks++;
    if (obs !== 10'b0000_1_1111_0) begin errors++; $display("FAIL async_blank: got %h required %h", obs, 10'b0000_1_1111_0); end
    @(negedge clk);
    n_rst = 1; run = 1; load = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL async_after c%0d: nothing queued, got %h", c, obs); end
      else begin ev = sb.pop_front(); if (obs !== ev) begin errors++; $display("FAIL async_after c%0d: got %h required %h", c, obs, ev); end end
      if (!dec_n_en || dig_n_sel != 4'hF) lit++;
    end
    checks++;
    if (lit != 0) begin errors++; $display("FAIL async_stays_blank: got %0d lit cycles required 0", lit); end
  endtask

  task automatic test_run_drop();
    logic [9:0] ev;
    int ph = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 0) begin bcd_data = 16'h4321; load = 1; end else load = 0;
      if (ph == 0 && m_scan && (m_pos % P) >= DIV) begin run = 0; ph = 1; end
      else if (ph == 1) begin run = 1; ph = 2; end
      else if (ph == 2) ph = 3;
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL run_drop c%0d: nothing queued, got %h", c, obs); end
      else begin ev = sb.pop_front(); if (obs !== ev) begin errors++; $display("FAIL run_drop c%0d: got %h required %h", c, obs, ev); end end
      if (ph == 1 && run == 0) begin
        checks++;
        if (obs !== 10'b0000_1_1111_0) begin errors++; $display("FAIL run_drop_idle: got %h required %h", obs, 10'b0000_1_1111_0); end
      end
      if (ph == 2) begin
        checks++;
        if ({dec_in, dig_n_sel, dec_n_en} !== {4'h1, 4'b1110, 1'b0}) begin errors++; $display("FAIL run_resume: got %h required %h", {dec_in, dig_n_sel, dec_n_en}, {4'h1, 4'b1110, 1'b0}); end
      end
    end
    checks++;
    if (ph != 3) begin errors++; $display("FAIL run_drop_reached: got phase %0d required 3", ph); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_load_timing();
    test_async_reset();
    test_run_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1000: clock cycles each digit is lit (SHOW time); legal range 2..65535.
REQ-002 Parameter GAP, default 8: blanking cycles between consecutive digits (anti-ghosting); legal range 1..255.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous assert, active-low.
REQ-005 bcd_data  input  16  four BCD digits; [3:0] digit 0 (least significant) through [15:12] digit 3.
REQ-006 load  input  1  one-cycle strobe; captures bcd_data into the shadow register.
REQ-007 run  input  1  1 = scanning permitted, 0 = force idle/blank.
REQ-008 lz_en  input  1  1 = leading-zero suppression on.
REQ-009 dec_in  output  4  nibble driven to the shared 7-segment decoder.
REQ-010 dec_n_en  output  1  decoder enable, active-low (1 = decoder output blank).
REQ-011 dig_n_sel  output  4  digit select, active-low one-hot; bit i lights digit i.
REQ-012 frame_done  output  1  one-cycle pulse per completed 4-digit frame.

Function
REQ-013 All outputs SHALL be registered; no combinational input-to-output path.
REQ-014 Shadow register: on an edge with load=1, shadow <= bcd_data and shadow_vld <= 1; shadow_vld is cleared only by reset.
REQ-015 FSM states: IDLE, SHOW, GAP; reset state IDLE.
REQ-016 IDLE: dec_n_en=1, dig_n_sel=4'b1111, dec_in=0; leave to SHOW with idx=0 when run=1 and shadow_vld=1 at the sampling edge.
REQ-017 Frame latch: on every transition into SHOW with idx=0, active <= shadow (current registered shadow, not same-edge bcd_data).
REQ-018 SHOW: lasts exactly DIV cycles (cnt 0..DIV-1); dec_in=active nibble idx; dig_n_sel bit idx = 0, others 1; dec_n_en=0 unless digit suppressed.
REQ-019 GAP: lasts exactly GAP cycles; dec_n_en=1, dig_n_sel=4'b1111, dec_in holds last value.
REQ-020 SHOW -> GAP at cnt=DIV-1; GAP -> SHOW at cnt=GAP-1 with idx <= idx+1 modulo 4 (3 wraps to 0, triggering REQ-017).
REQ-021 Frame period SHALL be 4*(DIV+GAP) cycles.
REQ-022 frame_done SHALL be 1 for exactly the first GAP cycle following SHOW of idx=3, 0 otherwise.
REQ-023 Leading-zero suppression: with lz_en=1, digit i (i=3,2,1) is suppressed when active digits 3..i are all 0; digit 0 never suppressed; lz_en sampled per SHOW cycle.
REQ-024 Suppressed digit: SHOW timing unchanged; dec_n_en=1 and dig_n_sel=4'b1111 for its whole SHOW.
REQ-025 Nibbles >9 SHALL be passed unchanged on dec_in with dec_n_en=0 (decoder blanks them).
REQ-026 load during SHOW/GAP SHALL not alter the digit being displayed; new value appears from next frame start.
REQ-027 load on the same edge as REQ-017 latch: active takes the pre-load shadow; new value shown from the following frame.
REQ-028 run=0 sampled in any state: next state IDLE, counters and idx cleared, frame_done=0, shadow retained.
REQ-029 Counter cnt width 16 bits; idx width 2 bits; wrap only as in REQ-020.

Reset
REQ-030 n_rst=0 SHALL immediately force: state IDLE, idx=0, cnt=0, shadow=0, active=0, shadow_vld=0, dec_in=0, dec_n_en=1, dig_n_sel=4'b1111, frame_done=0.
REQ-031 Reset asserted mid-SHOW SHALL blank outputs without waiting for a clock edge; after release the block stays IDLE until a new load.

Verification (DIV=4, GAP=2, frame = 24 cycles)
REQ-032 Reset release, run=1, load bcd_data=16'h1234 at edge e0 -> SHOW idx0 visible after e1: dec_in=4, dig_n_sel=4'b1110, dec_n_en=0 for 4 cycles, then 2 blank cycles, then dec_in=3, dig_n_sel=4'b1101.
REQ-033 Continuous run after REQ-032 -> frame_done pulses once every 24 cycles, each in the first GAP cycle after digit 3 (dec_in=1).
REQ-034 lz_en=1, load 16'h0050 -> digits 3 and 2 blank (dec_n_en=1, dig_n_sel=4'b1111) for their SHOW, digit 1 shows 5, digit 0 shows 0; load 16'h0000 -> only digit 0 lit, showing 0.
REQ-035 load 16'h9999 during SHOW of digit 1, then load 16'h5678 on the frame-latch edge -> rest of current frame unchanged, next frame shows 9999, frame after shows 5678.
REQ-036 n_rst=0 asserted mid-SHOW, asynchronous to clk -> dec_n_en=1, dig_n_sel=4'b1111 within the same cycle; after release with run=1 and no load, outputs remain blank for 100 cycles.
REQ-037 run dropped to 0 during GAP -> IDLE next edge, blank; run back to 1 -> SHOW idx0 with retained shadow after one edge.
